// File: rtl/pipe_pkg.sv
// Shared definitions for handshaked pipeline stage registers.
// State encoding doubles as the entry count of a stage.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   // Default bubble masks for the 24-bit control bundles.
   // ID/EX drops every control bit on a nop.
   localparam logic [23:0] ID_EX_KILL  = 24'hFF_FFFF;
   // EX/MEM only needs the low write/halt enables cleared.
   localparam logic [23:0] EX_MEM_KILL = 24'h00_00FF;

   // Entry count held in a given state.
   function automatic logic [1:0] st_occ(input state_t s);
      return 2'(s);
   endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for stall-cycle statistics.
// Stops at all-ones instead of wrapping.
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_max;

   assign w_max = &r_cnt;
   assign o_cnt = r_cnt;

   // Count enabled cycles until the top value is reached.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_en && !w_max) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with optional skid slot,
// hold, flush, nop-bubble insertion and a stall counter.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                DATA_W    = 48,
   parameter int                CTRL_W    = 24,
   parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}},
   parameter int                SKID      = 1,
   parameter int                CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              in_nop,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_rdy;
   logic [DATA_W-1:0]   r_head_data;
   logic [CTRL_W-1:0]   r_head_ctrl;
   logic [DATA_W-1:0]   r_skid_data;
   logic [CTRL_W-1:0]   r_skid_ctrl;
   logic                w_accept;
   logic                w_issue;
   logic                w_load_head;
   logic                w_load_skid;
   logic                w_skid_to_head;
   logic [CTRL_W-1:0]   w_in_ctrl;

   // With the skid slot, in_ready comes straight from a flop so
   // downstream ready never ripples upstream combinationally.
   assign in_ready = (SKID != 0)
                   ? (r_rdy & ~stall)
                   : (((r_state == EMPTY) | out_ready) & ~stall);

   assign out_valid = (r_state != EMPTY) & ~stall;
   assign out_data  = r_head_data;
   assign out_ctrl  = r_head_ctrl;
   assign occupancy = st_occ(r_state);

   assign w_accept  = in_valid & in_ready;
   assign w_issue   = out_valid & out_ready;
   assign w_in_ctrl = in_nop ? (in_ctrl & ~KILL_MASK) : in_ctrl;

   // Next state and slot steering; flush wins over everything.
   always_comb begin
      w_state_nxt    = r_state;
      w_load_head    = 1'b0;
      w_load_skid    = 1'b0;
      w_skid_to_head = 1'b0;
      if (flush) begin
         w_state_nxt = EMPTY;
      end else begin
         unique case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_state_nxt = ONE;
                  w_load_head = 1'b1;
               end
            end
            ONE: begin
               if (w_accept && w_issue) begin
                  w_load_head = 1'b1;
               end else if (w_issue) begin
                  w_state_nxt = EMPTY;
               end else if (w_accept && (SKID != 0)) begin
                  w_state_nxt = FULL;
                  w_load_skid = 1'b1;
               end
            end
            FULL: begin
               if (w_issue) begin
                  w_state_nxt    = ONE;
                  w_skid_to_head = 1'b1;
               end
            end
            default: begin
               w_state_nxt = EMPTY;
            end
         endcase
      end
   end

   // State register plus the registered ready flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= EMPTY;
         r_rdy   <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_rdy   <= (w_state_nxt != FULL);
      end
   end

   // Head and skid slots; flush clears control so no stale
   // enables are left behind on the output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head_data <= '0;
         r_head_ctrl <= '0;
         r_skid_data <= '0;
         r_skid_ctrl <= '0;
      end else if (flush) begin
         r_head_ctrl <= '0;
         r_skid_ctrl <= '0;
      end else begin
         if (w_load_head) begin
            r_head_data <= in_data;
            r_head_ctrl <= w_in_ctrl;
         end else if (w_skid_to_head) begin
            r_head_data <= r_skid_data;
            r_head_ctrl <= r_skid_ctrl;
         end
         if (w_load_skid) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= w_in_ctrl;
         end
      end
   end

   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_en    (stall),
      .o_cnt   (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed table, hand sequences
// and a random run against a queue-based reference model.
module tb_pipe_stage_skid;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_data;
   logic [7:0]  in_ctrl;
   logic        in_nop;
   logic        stall;
   logic        flush;
   logic        out_ready;

   logic        s1_in_ready, s1_out_valid;
   logic [15:0] s1_out_data;
   logic [7:0]  s1_out_ctrl;
   logic [1:0]  s1_occ;
   logic [15:0] s1_stall_cnt;

   logic        s0_in_ready, s0_out_valid;
   logic [15:0] s0_out_data;
   logic [7:0]  s0_out_ctrl;
   logic [1:0]  s0_occ;
   logic [15:0] s0_stall_cnt;

   logic        c3_in_ready, c3_out_valid;
   logic [15:0] c3_out_data;
   logic [7:0]  c3_out_ctrl;
   logic [1:0]  c3_occ;
   logic [2:0]  c3_stall_cnt;

   int n_checks = 0;
   int n_err    = 0;

   pipe_stage_skid #(
      .DATA_W(16), .CTRL_W(8), .KILL_MASK(8'hF0),
      .SKID(1), .CNT_W(16)
   ) u_s1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(s1_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .in_nop(in_nop),
      .stall(stall), .flush(flush),
      .out_valid(s1_out_valid), .out_ready(out_ready),
      .out_data(s1_out_data), .out_ctrl(s1_out_ctrl),
      .occupancy(s1_occ), .stall_cnt(s1_stall_cnt)
   );

   pipe_stage_skid #(
      .DATA_W(16), .CTRL_W(8), .KILL_MASK(8'hF0),
      .SKID(0), .CNT_W(16)
   ) u_s0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(s0_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .in_nop(in_nop),
      .stall(stall), .flush(flush),
      .out_valid(s0_out_valid), .out_ready(out_ready),
      .out_data(s0_out_data), .out_ctrl(s0_out_ctrl),
      .occupancy(s0_occ), .stall_cnt(s0_stall_cnt)
   );

   pipe_stage_skid #(
      .DATA_W(16), .CTRL_W(8), .KILL_MASK(8'hF0),
      .SKID(1), .CNT_W(3)
   ) u_c3 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(c3_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .in_nop(in_nop),
      .stall(stall), .flush(flush),
      .out_valid(c3_out_valid), .out_ready(out_ready),
      .out_data(c3_out_data), .out_ctrl(c3_out_ctrl),
      .occupancy(c3_occ), .stall_cnt(c3_stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h",
                  nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      in_data   = '0;
      in_ctrl   = '0;
      in_nop    = 1'b0;
      stall     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      logic        v;
      logic [15:0] d;
      logic [7:0]  c;
      logic        nop;
      logic        ordy;
      logic        stl;
      logic        e_rdy;
      logic        e_ov;
      logic [1:0]  e_occ;
      logic        dchk;
      logic [15:0] e_d;
      logic [7:0]  e_c;
   } vec_t;

   vec_t tbl[11];

   typedef struct packed {
      logic [15:0] d;
      logic [7:0]  c;
   } ent_t;

   ent_t q1[$];
   ent_t q0[$];

   initial begin
      rst = 1'b0;
      idle_inputs();

      // back-pressure, bubble and stall vectors for the skid stage
      tbl[0]  = '{1'b1, 16'h00A0, 8'h11, 1'b0, 1'b0, 1'b0,
                  1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 8'h00};
      tbl[1]  = '{1'b1, 16'h00B0, 8'h22, 1'b0, 1'b0, 1'b0,
                  1'b1, 1'b1, 2'd1, 1'b1, 16'h00A0, 8'h11};
      tbl[2]  = '{1'b1, 16'h00C0, 8'h33, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b1, 2'd2, 1'b1, 16'h00A0, 8'h11};
      tbl[3]  = '{1'b1, 16'h00C0, 8'h33, 1'b0, 1'b1, 1'b0,
                  1'b0, 1'b1, 2'd2, 1'b1, 16'h00A0, 8'h11};
      tbl[4]  = '{1'b1, 16'h00C0, 8'h33, 1'b0, 1'b1, 1'b0,
                  1'b1, 1'b1, 2'd1, 1'b1, 16'h00B0, 8'h22};
      tbl[5]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0,
                  1'b1, 1'b1, 2'd1, 1'b1, 16'h00C0, 8'h33};
      tbl[6]  = '{1'b1, 16'h5555, 8'hAB, 1'b1, 1'b0, 1'b0,
                  1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 8'h00};
      tbl[7]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b1, 1'b1, 2'd1, 1'b1, 16'h5555, 8'h0B};
      tbl[8]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1,
                  1'b0, 1'b0, 2'd1, 1'b1, 16'h5555, 8'h0B};
      tbl[9]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0,
                  1'b1, 1'b1, 2'd1, 1'b1, 16'h5555, 8'h0B};
      tbl[10] = '{1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0,
                  1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 8'h00};

      // reset state
      do_reset();
      #1;
      chk("rst_rdy", s1_in_ready, 1);
      chk("rst_ov", s1_out_valid, 0);
      chk("rst_occ", s1_occ, 0);
      chk("rst_data", s1_out_data, 0);
      chk("rst_ctrl", s1_out_ctrl, 0);
      chk("rst_scnt", s1_stall_cnt, 0);
      chk("rst_rdy0", s0_in_ready, 1);

      // table
      do_reset();
      for (int i = 0; i < 11; i++) begin
         in_valid  = tbl[i].v;
         in_data   = tbl[i].d;
         in_ctrl   = tbl[i].c;
         in_nop    = tbl[i].nop;
         out_ready = tbl[i].ordy;
         stall     = tbl[i].stl;
         #1;
         chk($sformatf("tbl%0d_rdy", i), s1_in_ready, tbl[i].e_rdy);
         chk($sformatf("tbl%0d_ov", i), s1_out_valid, tbl[i].e_ov);
         chk($sformatf("tbl%0d_occ", i), s1_occ, tbl[i].e_occ);
         if (tbl[i].dchk) begin
            chk($sformatf("tbl%0d_d", i), s1_out_data, tbl[i].e_d);
            chk($sformatf("tbl%0d_c", i), s1_out_ctrl, tbl[i].e_c);
         end
         @(negedge clk);
      end

      // streaming 1..16
      do_reset();
      for (int i = 0; i < 17; i++) begin
         in_valid  = (i < 16);
         in_data   = 16'(i + 1);
         in_ctrl   = 8'(i);
         out_ready = 1'b1;
         #1;
         if (i < 16) chk("stream_rdy", s1_in_ready, 1);
         if (i > 0) begin
            chk("stream_ov", s1_out_valid, 1);
            chk("stream_data", s1_out_data, 32'(i));
         end
         @(negedge clk);
      end

      // stall hold and counter saturation
      do_reset();
      in_valid = 1'b1;
      in_data  = 16'h1234;
      in_ctrl  = 8'h5A;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      stall     = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("stall_ov", s1_out_valid, 0);
         chk("stall_rdy", s1_in_ready, 0);
         chk("stall_data", s1_out_data, 16'h1234);
         chk("stall_occ", s1_occ, 1);
         @(negedge clk);
      end
      stall = 1'b0;
      #1;
      chk("stall_cnt5", s1_stall_cnt, 5);
      chk("stall_c3_5", c3_stall_cnt, 5);
      chk("stall_ov_rel", s1_out_valid, 1);
      stall = 1'b1;
      for (int i = 0; i < 5; i++) @(negedge clk);
      stall = 1'b0;
      #1;
      chk("stall_cnt10", s1_stall_cnt, 10);
      chk("stall_sat3", c3_stall_cnt, 7);
      @(negedge clk);

      // flush while FULL with stall and pending input
      do_reset();
      in_valid = 1'b1;
      in_data  = 16'h0A01;
      in_ctrl  = 8'hC1;
      @(negedge clk);
      in_data = 16'h0A02;
      in_ctrl = 8'hC2;
      @(negedge clk);
      #1;
      chk("fl_full", s1_occ, 2);
      in_data = 16'hDEAD;
      in_ctrl = 8'hEE;
      stall   = 1'b1;
      flush   = 1'b1;
      @(negedge clk);
      idle_inputs();
      out_ready = 1'b1;
      #1;
      chk("fl_occ", s1_occ, 0);
      chk("fl_ctrl", s1_out_ctrl, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("fl_ov", s1_out_valid, 0);
         @(negedge clk);
      end
      // flush while ONE with a same-cycle accept
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h0B01;
      in_ctrl   = 8'h77;
      @(negedge clk);
      in_data = 16'h0B02;
      in_ctrl = 8'h78;
      flush   = 1'b1;
      #1;
      chk("fl1_rdy", s1_in_ready, 1);
      @(negedge clk);
      idle_inputs();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("fl1_ov", s1_out_valid, 0);
         chk("fl1_occ", s1_occ, 0);
         chk("fl1_ctrl", s1_out_ctrl, 0);
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = 16'h0C01;
      in_ctrl  = 8'h3C;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("fl_next_ov", s1_out_valid, 1);
      chk("fl_next_d", s1_out_data, 16'h0C01);
      @(negedge clk);

      // reset while FULL, checked before any clock edge
      do_reset();
      stall = 1'b1;
      @(negedge clk);
      stall    = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h0D01;
      in_ctrl  = 8'h99;
      @(negedge clk);
      in_data = 16'h0D02;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("rm_full", s1_occ, 2);
      rst = 1'b0;
      #1;
      chk("rm_ov", s1_out_valid, 0);
      chk("rm_occ", s1_occ, 0);
      chk("rm_ctrl", s1_out_ctrl, 0);
      chk("rm_scnt", s1_stall_cnt, 0);
      chk("rm_rdy", s1_in_ready, 1);
      @(negedge clk);
      rst = 1'b1;

      // random run against queue models
      do_reset();
      begin
         int   nstall;
         logic z1, z0;
         logic r1, v1, r0, v0;
         ent_t e;
         nstall = 0;
         z1 = 1'b1;
         z0 = 1'b1;
         q1.delete();
         q0.delete();
         for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_nop    = ($urandom_range(0, 4) == 0);
            in_data   = 16'($urandom);
            in_ctrl   = 8'($urandom);
            #1;
            r1 = (q1.size() < 2) && !stall;
            v1 = (q1.size() > 0) && !stall;
            r0 = ((q0.size() == 0) || out_ready) && !stall;
            v0 = (q0.size() > 0) && !stall;
            chk("r_rdy1", s1_in_ready, r1);
            chk("r_ov1", s1_out_valid, v1);
            chk("r_occ1", s1_occ, q1.size());
            if (q1.size() > 0) begin
               chk("r_d1", s1_out_data, q1[0].d);
               chk("r_c1", s1_out_ctrl, q1[0].c);
            end else if (z1) begin
               chk("r_z1", s1_out_ctrl, 0);
            end
            chk("r_rdy0", s0_in_ready, r0);
            chk("r_ov0", s0_out_valid, v0);
            chk("r_occ0", s0_occ, q0.size());
            if (q0.size() > 0) begin
               chk("r_d0", s0_out_data, q0[0].d);
               chk("r_c0", s0_out_ctrl, q0[0].c);
            end else if (z0) begin
               chk("r_z0", s0_out_ctrl, 0);
            end
            chk("r_scnt", s1_stall_cnt,
                (nstall > 65535) ? 65535 : nstall);
            chk("r_scnt3", c3_stall_cnt,
                (nstall > 7) ? 7 : nstall);
            e.d = in_data;
            e.c = in_nop ? (in_ctrl & 8'h0F) : in_ctrl;
            if (stall) nstall++;
            if (flush) begin
               q1.delete();
               q0.delete();
               z1 = 1'b1;
               z0 = 1'b1;
            end else begin
               if (v1 && out_ready) void'(q1.pop_front());
               if (in_valid && r1) begin
                  q1.push_back(e);
                  z1 = 1'b0;
               end
               if (v0 && out_ready) void'(q0.pop_front());
               if (in_valid && r0) begin
                  q0.push_back(e);
                  z0 = 1'b0;
               end
            end
            @(negedge clk);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, handshaked pipeline stage register: the generic successor of the fixed per-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data bundle and a control bundle between stages with valid/ready flow control, hold (stall), flush, and nop-bubble insertion that zeroes a masked subset of control bits.
- Optional 2-entry skid buffer registers in_ready so back-pressure does not form a combinational path across stages.
- Includes a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 48: width of the data bundle (operands, immediate, PC+2).
- CTRL_W, 24: width of the control bundle (ALU op, mem/reg write enables, halt, etc.).
- KILL_MASK, {CTRL_W{1'b1}}: control bits forced to 0 when an entry is accepted as a bubble (nop).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single entry, in_ready = ~full | out_ready.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_nop  in  1  accepted entry is a bubble; KILL_MASK bits of in_ctrl stored as 0.
- stall  in  1  freeze the stage: no accept, no issue, contents held.
- flush  in  1  discard all held entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head.
- out_data  out  DATA_W  head data.
- out_ctrl  out  CTRL_W  head control.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  cycles with stall=1, saturating.

Behaviour:
- Reset (rst=0, async):
  - occupancy=0, out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0.
  - in_ready=1 (SKID=1) or follows its formula (SKID=0).
  - Release is applied synchronously to clk.
- Handshakes:
  - accept = in_valid & in_ready.
  - issue = out_valid & out_ready.
  - in_ready must not depend on in_valid.
- State machine (SKID=1): EMPTY, ONE, FULL.
  - EMPTY, accept → ONE.
  - ONE, accept & ~issue → FULL.
  - ONE, issue & ~accept → EMPTY.
  - ONE, accept & issue → ONE; the new entry becomes head.
  - FULL, issue → ONE; the skid entry moves to head.
  - in_ready = registered (state != FULL).
  - out_valid = (state != EMPTY) & ~stall.
- SKID=0: state is EMPTY or ONE only. Accept-and-issue in the same cycle keeps ONE and replaces the head.
- Latency: one cycle from accept to out_valid when the stage is empty. Order is strictly FIFO.
- Bubble: on accept with in_nop=1, stored ctrl = in_ctrl & ~KILL_MASK. Data is stored unchanged. The entry still occupies a slot and issues normally.
- Stall:
  - in_ready forced 0 and out_valid forced 0, so no handshake completes.
  - State, data and ctrl registers hold; out_data and out_ctrl keep driving the head unchanged.
  - stall_cnt increments each cycle and saturates at all-ones (no wrap).
- Flush:
  - Next state is EMPTY; out_valid=0 the following cycle.
  - A same-cycle accept is discarded.
  - Flush overrides stall.
  - Held ctrl registers are cleared to 0; data registers may hold.
  - stall_cnt is unaffected by flush.
- Priority: rst > flush > stall > normal handshakes.
- Output values are undefined-free: when out_valid=0 after a flush, out_ctrl=0 so no stale write enable is visible.

Decomposition:
- Shared package pipe_pkg holds the state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and the default KILL_MASK constants per stage (ID_EX_KILL, EX_MEM_KILL).
- One natural sub-module, pipe_sat_counter (CNT_W, increment enable, saturate), used for stall_cnt.
- The entry store lives inline as two slot registers (head, skid) with a mux.

Test Plan:
- Reset mid-transfer: FULL with two entries, assert rst=0 → out_valid=0, occupancy=0, out_ctrl=0 immediately (before the clock edge); stall_cnt=0.
- Streaming, SKID=1: in_valid=1 every cycle, out_ready=1, data 0x0001..0x0010 → out_data 0x0001..0x0010 in order with 1-cycle latency and in_ready constantly 1.
- Back-pressure: out_ready=0 for 3 cycles while sending A, B, C → A and B held (occupancy=2), in_ready=0 from the 3rd cycle, C not lost. Releasing out_ready → A, B, C issue in order.
- Bubble: CTRL_W=8, KILL_MASK=8'hF0, in_ctrl=8'hAB, in_nop=1 → out_ctrl=8'h0B with out_data unchanged.
- Stall: hold stall=1 for 5 cycles with ONE occupied → out_valid=0, out_data stable, stall_cnt=5. With CNT_W=3 and 10 stall cycles → stall_cnt=7.
- Flush with simultaneous accept and stall while FULL → next cycle occupancy=0, out_valid=0, out_ctrl=0. The flushed entry and the same-cycle input never appear at the output.
